// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8x16 register file with one read port, sequenced by an
// IDLE/READ_A/READ_B/HOLD FSM. Define OPERAND_FETCH_BYPASS_EN for write-to-read forwarding.
module operand_fetch #(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [$clog2(NREG)-1:0] req_rn_a,
  input  logic [$clog2(NREG)-1:0] req_rn_b,
  input  logic [1:0]              req_shift,
  input  logic                    w_en,
  input  logic [$clog2(NREG)-1:0] w_num,
  input  logic [W-1:0]            w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            a_out,
  output logic [W-1:0]            b_out,
  output logic [1:0]              shift_out
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    regs_q [NREG];
  logic [RW-1:0]   rn_a_q, rn_b_q;
  logic [1:0]      shift_q;
  logic [W-1:0]    a_q, b_q;
  logic            req_ready_q, out_valid_q;
  logic [RW-1:0]   rd_num;
  logic [W-1:0]    rd_data;

  // Single read port, steered by the FSM to whichever operand is being fetched.
  always_comb begin
    rd_num  = (state_q == READ_B) ? rn_b_q : rn_a_q;
    rd_data = regs_q[rd_num];
`ifdef OPERAND_FETCH_BYPASS_EN
    if (w_en && (w_num == rd_num)) rd_data = w_data;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = READ_A;
      READ_A:  state_d = READ_B;
      READ_B:  state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
    end
  end

  // Write port runs regardless of FSM state; reads in the same edge see the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (w_en) begin
      regs_q[w_num] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rn_a_q  <= '0;
      rn_b_q  <= '0;
      shift_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        rn_a_q  <= req_rn_a;
        rn_b_q  <= req_rn_b;
        shift_q <= req_shift;
      end
      if (state_q == READ_A) a_q <= rd_data;
      if (state_q == READ_B) b_q <= rd_data;
    end
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_rn_a = '0, req_rn_b = '0;
  logic [1:0]  req_shift = '0;
  logic        w_en = 1'b0;
  logic [2:0]  w_num = '0;
  logic [15:0] w_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] a_out, b_out;
  logic [1:0]  shift_out;

  int total = 0;
  int bad   = 0;

  operand_fetch #(.W(16), .NREG(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rn_a(req_rn_a), .req_rn_b(req_rn_b), .req_shift(req_shift),
    .w_en(w_en), .w_num(w_num), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction; A is fetched one edge after
  // acceptance, B the edge after that, then the result is held until taken.
  logic [15:0] m_regs [8];
  logic        busy;
  int          phase;
  logic [2:0]  m_rna, m_rnb;
  logic [1:0]  m_sh;
  logic [15:0] m_a, m_b;
  wire         exp_rdy = !busy;
  wire         exp_vld = busy && (phase == 2);

  function automatic logic [15:0] fetch(input logic [2:0] rn);
`ifdef OPERAND_FETCH_BYPASS_EN
    if (w_en && w_num == rn) return w_data;
`endif
    return m_regs[rn];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0; phase <= 0; m_a <= '0; m_b <= '0; m_sh <= '0;
      m_rna <= '0; m_rnb <= '0;
      for (int i = 0; i < 8; i++) m_regs[i] <= '0;
    end else begin
      if (!busy) begin
        if (req_valid) begin
          busy <= 1'b1; phase <= 0;
          m_rna <= req_rn_a; m_rnb <= req_rn_b; m_sh <= req_shift;
        end
      end else if (phase == 0) begin
        m_a <= fetch(m_rna); phase <= 1;
      end else if (phase == 1) begin
        m_b <= fetch(m_rnb); phase <= 2;
      end else if (out_ready) begin
        busy <= 1'b0;
      end
      if (w_en) m_regs[w_num] <= w_data;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
      if (exp_vld) begin
        chk("a_out", {16'b0, a_out}, {16'b0, m_a});
        chk("b_out", {16'b0, b_out}, {16'b0, m_b});
        chk("shift_out", {30'b0, shift_out}, {30'b0, m_sh});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] n, input logic [15:0] d);
    w_en = 1'b1; w_num = n; w_data = d;
    step();
    w_en = 1'b0;
  endtask

  // Returns just after the accepting edge (DUT then in READ_A).
  task automatic request(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    int n = 0;
    req_valid = 1'b1; req_rn_a = a; req_rn_b = b; req_shift = s;
    while (!req_ready && n < 20) begin step(); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    #12 reset_n = 1'b1;
    #1;
    step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", {16'b0, a_out}, 32'd0);
    chk("rst_shift", {30'b0, shift_out}, 32'd0);

    // Basic fetch and latency
    wr(3'd3, 16'h000C);
    wr(3'd5, 16'h002C);
    request(3'd3, 3'd5, 2'b11);
    chk("lat_n1", {31'b0, out_valid}, 32'd0);
    step();
    chk("lat_n2", {31'b0, out_valid}, 32'd0);
    step();
    chk("lat_n3", {31'b0, out_valid}, 32'd1);
    chk("t1_a", {16'b0, a_out}, 32'h000C);
    chk("t1_b", {16'b0, b_out}, 32'h002C);
    chk("t1_shift", {30'b0, shift_out}, 32'd3);

    // Backpressure with a write to an already-latched register
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin w_en = 1'b1; w_num = 3'd5; w_data = 16'hFFFF; end
      step();
      w_en = 1'b0;
      chk("bp_a", {16'b0, a_out}, 32'h000C);
      chk("bp_b", {16'b0, b_out}, 32'h002C);
      chk("bp_rdy", {31'b0, req_ready}, 32'd0);
    end
    take();
    chk("bp_done_vld", {31'b0, out_valid}, 32'd0);
    chk("bp_done_rdy", {31'b0, req_ready}, 32'd1);

    // Same-cycle read/write of the register being fetched
    wr(3'd1, 16'h0001);
    request(3'd1, 3'd2, 2'b00);
    w_en = 1'b1; w_num = 3'd1; w_data = 16'h8000;
    step();
    w_en = 1'b0;
    step();
`ifdef OPERAND_FETCH_BYPASS_EN
    chk("conf_a", {16'b0, a_out}, 32'h8000);
`else
    chk("conf_a", {16'b0, a_out}, 32'h0001);
`endif
    take();
    request(3'd1, 3'd1, 2'b00);
    wait_vld();
    chk("conf_reread_a", {16'b0, a_out}, 32'h8000);
    chk("conf_reread_b", {16'b0, b_out}, 32'h8000);
    take();

    // Same register twice, then a request arriving during HOLD
    wr(3'd2, 16'h2222);
    wr(3'd4, 16'h4444);
    wr(3'd7, 16'h1234);
    request(3'd7, 3'd7, 2'b01);
    wait_vld();
    chk("same_a", {16'b0, a_out}, 32'h1234);
    chk("same_b", {16'b0, b_out}, 32'h1234);
    req_valid = 1'b1; req_rn_a = 3'd2; req_rn_b = 3'd4; req_shift = 2'b10;
    repeat (3) begin
      step();
      chk("hold_ign_a", {16'b0, a_out}, 32'h1234);
      chk("hold_ign_rdy", {31'b0, req_ready}, 32'd0);
    end
    take();
    chk("hold_idle_rdy", {31'b0, req_ready}, 32'd1);
    request(3'd2, 3'd4, 2'b10);
    wait_vld();
    chk("late_a", {16'b0, a_out}, 32'h2222);
    chk("late_b", {16'b0, b_out}, 32'h4444);
    chk("late_shift", {30'b0, shift_out}, 32'd2);
    take();

    // Reset during READ_B
    request(3'd0, 3'd1, 2'b00);
    step();
    #3 reset_n = 1'b0;
    #1;
    chk("mrst_vld", {31'b0, out_valid}, 32'd0);
    chk("mrst_rdy", {31'b0, req_ready}, 32'd1);
    step();
    reset_n = 1'b1;
    request(3'd1, 3'd5, 2'b00);
    wait_vld();
    chk("mrst_a", {16'b0, a_out}, 32'h0000);
    chk("mrst_b", {16'b0, b_out}, 32'h0000);
    take();

    // Randomized traffic; the requester holds a pending request until accepted
    for (int i = 0; i < 3000; i++) begin
      if (!(req_valid && !req_ready)) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_rn_a  = 3'($urandom_range(0, 7));
        req_rn_b  = 3'($urandom_range(0, 7));
        req_shift = 2'($urandom_range(0, 3));
      end
      w_en      = ($urandom_range(0, 1) == 1);
      w_num     = 3'($urandom_range(0, 7));
      w_data    = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0; w_en = 1'b0; out_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
